// File: rtl/note_playback_sequencer_if.sv
// Note-memory side of the playback sequencer: rewind/advance/mix controls to the
// read-address counter and the note word plus finish flag coming back from it.
//   reader_listen : one-cycle rewind pulse (sequencer -> counter)
//   reader_read   : one-cycle advance pulse (sequencer -> counter)
//   reader_mix    : mix-track limit select, held for the whole playback
//   note_data     : {duration code, note code} at the current address
//   finish        : counter has passed its limit
interface note_playback_sequencer_if #(
    parameter int unsigned NOTE_W = 5,
    parameter int unsigned DUR_W  = 3
);
    logic                    reader_listen;
    logic                    reader_read;
    logic                    reader_mix;
    logic [NOTE_W+DUR_W-1:0] note_data;
    logic                    finish;

    modport master (
        output reader_listen,
        output reader_read,
        output reader_mix,
        input  note_data,
        input  finish
    );

    modport slave (
        input  reader_listen,
        input  reader_read,
        input  reader_mix,
        output note_data,
        output finish
    );
endinterface

// File: rtl/note_playback_sequencer.sv
// Melody playback sequencer: rewinds the note-address counter, fetches each note
// word, sounds it for its encoded number of beats, inserts a silent gap, then
// advances until the counter reports finish.
// Ports:
//   clock, reset      : system clock, asynchronous active-high reset
//   play_req          : start playback (sampled only while idle)
//   mix_req           : mix-track select, latched with an accepted play_req
//   stop_req          : abort playback from any non-idle state
//   rd                : counter/ROM interface (master side)
//   tone_code, tone_en: note code and audible flag to the synthesiser
//   busy              : high whenever not idle
//   done              : one-cycle pulse on normal completion
// Build option: define PLAYBACK_LOOP_EN to restart playback after each pass
// (done still pulses every pass) until stop_req or reset.
module note_playback_sequencer #(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned GAP_CYCLES = 2500000,
    parameter int unsigned NOTE_W     = 5,
    parameter int unsigned DUR_W      = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         play_req,
    input  logic                         mix_req,
    input  logic                         stop_req,
    note_playback_sequencer_if.master    rd,
    output logic [NOTE_W-1:0]            tone_code,
    output logic                         tone_en,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned PRE_LAST = (TICK_DIV > 0) ? TICK_DIV - 1 : 0;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_ADVANCE,
        S_CHECK,
        S_DONE,
        S_STOP
    } state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [DUR_W-1:0]   beat_cnt;
    logic [DUR_W-1:0]   dur_reg;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NOTE_W-1:0]  word_note;
    logic [DUR_W-1:0]   word_dur;

    assign word_note = rd.note_data[NOTE_W-1:0];
    assign word_dur  = rd.note_data[NOTE_W+DUR_W-1:NOTE_W];

    // Sequencer state, timing counters and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            pre_cnt          <= '0;
            beat_cnt         <= '0;
            dur_reg          <= '0;
            gap_cnt          <= '0;
            rd.reader_listen <= 1'b0;
            rd.reader_read   <= 1'b0;
            rd.reader_mix    <= 1'b0;
            tone_code        <= '0;
            tone_en          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // Pulse outputs fall back to low unless a transition below raises them.
            rd.reader_listen <= 1'b0;
            rd.reader_read   <= 1'b0;
            done             <= 1'b0;

            // Abort wins over any progress; STOP itself always finishes into IDLE.
            if (stop_req && state != S_IDLE && state != S_STOP) begin
                state            <= S_STOP;
                tone_en          <= 1'b0;
                rd.reader_listen <= 1'b1;
                rd.reader_mix    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play_req) begin
                            state            <= S_CLEAR;
                            rd.reader_listen <= 1'b1;
                            rd.reader_mix    <= mix_req;
                            busy             <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        state <= S_FETCH;
                    end
                    S_FETCH: begin
                        tone_code <= word_note;
                        dur_reg   <= word_dur;
                        tone_en   <= (word_note != '0);
                        pre_cnt   <= '0;
                        beat_cnt  <= '0;
                        state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        // Beat count runs 0..dur, so the note lasts (dur+1) beats.
                        if (pre_cnt == PRE_W'(PRE_LAST)) begin
                            pre_cnt <= '0;
                            if (beat_cnt == dur_reg) begin
                                tone_en <= 1'b0;
                                if (GAP_CYCLES == 0) begin
                                    state          <= S_ADVANCE;
                                    rd.reader_read <= 1'b1;
                                end else begin
                                    state   <= S_GAP;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + DUR_W'(1);
                            end
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_LAST)) begin
                            state          <= S_ADVANCE;
                            rd.reader_read <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    S_ADVANCE: begin
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        // finish already reflects the advance issued in ADVANCE.
                        if (rd.finish) begin
                            state <= S_DONE;
                            done  <= 1'b1;
`ifndef PLAYBACK_LOOP_EN
                            rd.reader_mix <= 1'b0;
`endif
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                    S_DONE: begin
`ifdef PLAYBACK_LOOP_EN
                        state            <= S_CLEAR;
                        rd.reader_listen <= 1'b1;
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state         <= S_IDLE;
                        tone_en       <= 1'b0;
                        rd.reader_mix <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
